// File: rtl/axi4_bram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_bram_ctrl
//  Description : AXI4 slave to single-port BRAM bridge. Handles one burst at
//                a time (FIXED/INCR/WRAP, narrow sizes) and arbitrates reads
//                and writes round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_bram_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    clock,
   input  logic                    resetn,
   // AW
   output logic                    axi4_aw_ready,
   input  logic                    axi4_aw_valid,
   input  logic [ID_WIDTH-1:0]     axi4_aw_id,
   input  logic [ADDR_WIDTH-1:0]   axi4_aw_addr,
   input  logic [7:0]              axi4_aw_len,
   input  logic [2:0]              axi4_aw_size,
   input  logic [1:0]              axi4_aw_burst,
   // W
   output logic                    axi4_w_ready,
   input  logic                    axi4_w_valid,
   input  logic [DATA_WIDTH-1:0]   axi4_w_data,
   input  logic [DATA_WIDTH/8-1:0] axi4_w_strb,
   input  logic                    axi4_w_last,
   // B
   input  logic                    axi4_b_ready,
   output logic                    axi4_b_valid,
   output logic [ID_WIDTH-1:0]     axi4_b_id,
   output logic [1:0]              axi4_b_resp,
   // AR
   output logic                    axi4_ar_ready,
   input  logic                    axi4_ar_valid,
   input  logic [ID_WIDTH-1:0]     axi4_ar_id,
   input  logic [ADDR_WIDTH-1:0]   axi4_ar_addr,
   input  logic [7:0]              axi4_ar_len,
   input  logic [2:0]              axi4_ar_size,
   input  logic [1:0]              axi4_ar_burst,
   // R
   input  logic                    axi4_r_ready,
   output logic                    axi4_r_valid,
   output logic [ID_WIDTH-1:0]     axi4_r_id,
   output logic [DATA_WIDTH-1:0]   axi4_r_data,
   output logic [1:0]              axi4_r_resp,
   output logic                    axi4_r_last,
   // BRAM
   output logic [ADDR_WIDTH-1:0]   bram_addr,
   output logic                    bram_en,
   output logic [DATA_WIDTH/8-1:0] bram_we,
   output logic [DATA_WIDTH-1:0]   bram_wdata,
   input  logic [DATA_WIDTH-1:0]   bram_rdata
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_DATA  = 3'd1,
      S_WR_RESP  = 3'd2,
      S_RD_ISSUE = 3'd3,
      S_RD_WAIT  = 3'd4,
      S_RD_VALID = 3'd5
   } state_t;

   state_t                  state_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [7:0]              len_q;
   logic [7:0]              cnt_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic                    wr_prio_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic [ADDR_WIDTH-1:0]   step;
   logic [ADDR_WIDTH-1:0]   mask;
   logic [31:0]             wrap_bytes;
   logic                    w_hs;
   logic                    beat_last;
   logic                    w_last_unused;

   // The burst length is counted, so w_last carries no extra information.
   assign w_last_unused = axi4_w_last;

   assign w_hs      = (state_q == S_WR_DATA) && axi4_w_valid;
   assign beat_last = (cnt_q == len_q);

   always_comb begin
      step       = ADDR_WIDTH'(1) << size_q;
      wrap_bytes = (32'(len_q) + 32'd1) << size_q;
      mask       = ADDR_WIDTH'(wrap_bytes - 32'd1);
      case (burst_q)
         2'b00:   addr_d = addr_q;
         2'b10:   addr_d = (addr_q & ~mask) | ((addr_q + step) & mask);
         default: addr_d = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
      endcase
   end

   // Readys are gated by resetn so every output is low while reset is held.
   always_comb begin
      axi4_aw_ready = resetn && (state_q == S_IDLE) && axi4_aw_valid
                      && (!axi4_ar_valid || wr_prio_q);
      axi4_ar_ready = resetn && (state_q == S_IDLE) && axi4_ar_valid
                      && (!axi4_aw_valid || !wr_prio_q);
      axi4_w_ready  = (state_q == S_WR_DATA);
      axi4_b_valid  = (state_q == S_WR_RESP);
      axi4_b_id     = id_q;
      axi4_b_resp   = 2'b00;
      axi4_r_valid  = (state_q == S_RD_VALID);
      axi4_r_id     = id_q;
      axi4_r_data   = rdata_q;
      axi4_r_resp   = 2'b00;
      axi4_r_last   = (state_q == S_RD_VALID) && beat_last;
      bram_en       = w_hs || (state_q == S_RD_ISSUE);
      bram_we       = w_hs ? axi4_w_strb : '0;
      bram_wdata    = w_hs ? axi4_w_data : '0;
      bram_addr     = bram_en ? (addr_q & ~ADDR_WIDTH'(STRB_WIDTH - 1)) : '0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         wr_prio_q <= 1'b1;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (axi4_aw_ready) begin
                  id_q      <= axi4_aw_id;
                  addr_q    <= axi4_aw_addr;
                  len_q     <= axi4_aw_len;
                  size_q    <= axi4_aw_size;
                  burst_q   <= axi4_aw_burst;
                  cnt_q     <= '0;
                  wr_prio_q <= 1'b0;
                  state_q   <= S_WR_DATA;
               end else if (axi4_ar_ready) begin
                  id_q      <= axi4_ar_id;
                  addr_q    <= axi4_ar_addr;
                  len_q     <= axi4_ar_len;
                  size_q    <= axi4_ar_size;
                  burst_q   <= axi4_ar_burst;
                  cnt_q     <= '0;
                  wr_prio_q <= 1'b1;
                  state_q   <= S_RD_ISSUE;
               end
            end
            S_WR_DATA: begin
               if (axi4_w_valid) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q + 8'd1;
                  if (beat_last) begin
                     state_q <= S_WR_RESP;
                  end
               end
            end
            S_WR_RESP: begin
               if (axi4_b_ready) begin
                  state_q <= S_IDLE;
               end
            end
            S_RD_ISSUE: state_q <= S_RD_WAIT;
            S_RD_WAIT: begin
               rdata_q <= bram_rdata;
               state_q <= S_RD_VALID;
            end
            S_RD_VALID: begin
               if (axi4_r_ready) begin
                  if (beat_last) begin
                     state_q <= S_IDLE;
                  end else begin
                     addr_q  <= addr_d;
                     cnt_q   <= cnt_q + 8'd1;
                     state_q <= S_RD_ISSUE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_bram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_bram_ctrl
//  Description : Scoreboard bench for axi4_bram_ctrl with a behavioural BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_bram_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic        axi4_aw_ready, axi4_aw_valid;
   logic [3:0]  axi4_aw_id;
   logic [15:0] axi4_aw_addr;
   logic [7:0]  axi4_aw_len;
   logic [2:0]  axi4_aw_size;
   logic [1:0]  axi4_aw_burst;
   logic        axi4_w_ready, axi4_w_valid, axi4_w_last;
   logic [63:0] axi4_w_data;
   logic [7:0]  axi4_w_strb;
   logic        axi4_b_ready, axi4_b_valid;
   logic [3:0]  axi4_b_id;
   logic [1:0]  axi4_b_resp;
   logic        axi4_ar_ready, axi4_ar_valid;
   logic [3:0]  axi4_ar_id;
   logic [15:0] axi4_ar_addr;
   logic [7:0]  axi4_ar_len;
   logic [2:0]  axi4_ar_size;
   logic [1:0]  axi4_ar_burst;
   logic        axi4_r_ready, axi4_r_valid, axi4_r_last;
   logic [3:0]  axi4_r_id;
   logic [63:0] axi4_r_data;
   logic [1:0]  axi4_r_resp;
   logic [15:0] bram_addr;
   logic        bram_en;
   logic [7:0]  bram_we;
   logic [63:0] bram_wdata;
   logic [63:0] bram_rdata = '0;

   axi4_bram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .ID_WIDTH(4)) dut (
      .clock(clock), .resetn(resetn),
      .axi4_aw_ready(axi4_aw_ready), .axi4_aw_valid(axi4_aw_valid), .axi4_aw_id(axi4_aw_id),
      .axi4_aw_addr(axi4_aw_addr), .axi4_aw_len(axi4_aw_len), .axi4_aw_size(axi4_aw_size),
      .axi4_aw_burst(axi4_aw_burst),
      .axi4_w_ready(axi4_w_ready), .axi4_w_valid(axi4_w_valid), .axi4_w_data(axi4_w_data),
      .axi4_w_strb(axi4_w_strb), .axi4_w_last(axi4_w_last),
      .axi4_b_ready(axi4_b_ready), .axi4_b_valid(axi4_b_valid), .axi4_b_id(axi4_b_id),
      .axi4_b_resp(axi4_b_resp),
      .axi4_ar_ready(axi4_ar_ready), .axi4_ar_valid(axi4_ar_valid), .axi4_ar_id(axi4_ar_id),
      .axi4_ar_addr(axi4_ar_addr), .axi4_ar_len(axi4_ar_len), .axi4_ar_size(axi4_ar_size),
      .axi4_ar_burst(axi4_ar_burst),
      .axi4_r_ready(axi4_r_ready), .axi4_r_valid(axi4_r_valid), .axi4_r_id(axi4_r_id),
      .axi4_r_data(axi4_r_data), .axi4_r_resp(axi4_r_resp), .axi4_r_last(axi4_r_last),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   always #5 clock = ~clock;

   // Behavioural single-port BRAM, one-cycle read latency.
   bit [63:0] mem [0:8191];
   always @(posedge clock) begin
      if (bram_en) begin
         if (bram_we != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
               if (bram_we[i]) mem[bram_addr[15:3]][i*8 +: 8] = bram_wdata[i*8 +: 8];
            end
         end else begin
            bram_rdata <= mem[bram_addr[15:3]];
         end
      end
   end

   typedef struct { logic [15:0] a; logic [7:0] we; logic [63:0] d; } bexp_t;
   typedef struct { logic [3:0] id; logic [63:0] d; logic last; } rexp_t;
   bexp_t      bq[$];
   rexp_t      rq[$];
   logic [3:0] respq[$];
   bit         gq[$];
   bit         track_grants = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout/unexpected expected event", nm);
   endtask

   function automatic logic [63:0] pat(input logic [15:0] a);
      return 64'hDEAD_BEEF_0000_0000 | 64'(a);
   endfunction

   task automatic push_bram(input logic [15:0] a, input logic [7:0] we, input logic [63:0] d);
      bexp_t e;
      e.a = a; e.we = we; e.d = d;
      bq.push_back(e);
   endtask

   task automatic push_r(input logic [3:0] id, input logic [63:0] d, input logic last);
      rexp_t e;
      e.id = id; e.d = d; e.last = last;
      rq.push_back(e);
   endtask

   // Monitor: pops expectations whenever the DUT presents a transfer.
   always @(negedge clock) begin
      bexp_t be;
      rexp_t re;
      logic [3:0] bid;
      bit g;
      if (resetn) begin
         if (bram_en) begin
            if (bq.size() == 0) fail_now("bram_unexpected_access");
            else begin
               be = bq.pop_front();
               chk("bram_addr", 64'(bram_addr), 64'(be.a));
               chk("bram_we", 64'(bram_we), 64'(be.we));
               if (be.we != 8'h00) chk("bram_wdata", bram_wdata, be.d);
            end
         end
         if (axi4_b_valid && axi4_b_ready) begin
            if (respq.size() == 0) fail_now("b_unexpected");
            else begin
               bid = respq.pop_front();
               chk("b_id", 64'(axi4_b_id), 64'(bid));
               chk("b_resp", 64'(axi4_b_resp), 64'd0);
            end
         end
         if (axi4_r_valid && axi4_r_ready) begin
            if (rq.size() == 0) fail_now("r_unexpected");
            else begin
               re = rq.pop_front();
               chk("r_id", 64'(axi4_r_id), 64'(re.id));
               chk("r_data", axi4_r_data, re.d);
               chk("r_last", 64'(axi4_r_last), 64'(re.last));
               chk("r_resp", 64'(axi4_r_resp), 64'd0);
            end
         end
         if (track_grants && ((axi4_aw_valid && axi4_aw_ready) || (axi4_ar_valid && axi4_ar_ready))) begin
            if (gq.size() == 0) fail_now("grant_unexpected");
            else begin
               g = gq.pop_front();
               chk("grant_is_write", 64'(axi4_aw_valid && axi4_aw_ready), 64'(g));
            end
         end
      end
   end

   task automatic aw_send(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
      int n = 0;
      axi4_aw_id = id; axi4_aw_addr = a; axi4_aw_len = len;
      axi4_aw_size = sz; axi4_aw_burst = bu; axi4_aw_valid = 1'b1;
      @(negedge clock);
      while (!axi4_aw_ready && n < 300) begin @(negedge clock); n++; end
      if (!axi4_aw_ready) fail_now("aw_handshake");
      @(posedge clock); #1;
      axi4_aw_valid = 1'b0;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
      int n = 0;
      axi4_ar_id = id; axi4_ar_addr = a; axi4_ar_len = len;
      axi4_ar_size = sz; axi4_ar_burst = bu; axi4_ar_valid = 1'b1;
      @(negedge clock);
      while (!axi4_ar_ready && n < 300) begin @(negedge clock); n++; end
      if (!axi4_ar_ready) fail_now("ar_handshake");
      @(posedge clock); #1;
      axi4_ar_valid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic last);
      int n = 0;
      axi4_w_data = d; axi4_w_strb = s; axi4_w_last = last; axi4_w_valid = 1'b1;
      @(negedge clock);
      while (!axi4_w_ready && n < 300) begin @(negedge clock); n++; end
      if (!axi4_w_ready) fail_now("w_handshake");
      @(posedge clock); #1;
      axi4_w_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((bq.size() != 0 || rq.size() != 0 || respq.size() != 0) && n < 500) begin
         @(negedge clock); n++;
      end
      if (n >= 500) fail_now("drain");
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      resetn = 1'b0;
      axi4_aw_valid = 1'b1; axi4_ar_valid = 1'b1; axi4_w_valid = 1'b0;
      axi4_aw_id = 4'h3; axi4_aw_addr = 16'h0100; axi4_aw_len = 8'd0; axi4_aw_size = 3'd3;
      axi4_aw_burst = 2'b01; axi4_ar_id = 4'h3; axi4_ar_addr = 16'h0100; axi4_ar_len = 8'd0;
      axi4_ar_size = 3'd3; axi4_ar_burst = 2'b01;
      axi4_w_data = '0; axi4_w_strb = '0; axi4_w_last = 1'b0;
      axi4_b_ready = 1'b1; axi4_r_ready = 1'b1;

      // Reset state: valids held high must not produce a ready.
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_aw_ready", 64'(axi4_aw_ready), 64'd0);
      chk("rst_ar_ready", 64'(axi4_ar_ready), 64'd0);
      chk("rst_w_ready", 64'(axi4_w_ready), 64'd0);
      chk("rst_b_valid", 64'(axi4_b_valid), 64'd0);
      chk("rst_r_valid", 64'(axi4_r_valid), 64'd0);
      chk("rst_r_data", axi4_r_data, 64'd0);
      chk("rst_bram_en", 64'(bram_en), 64'd0);
      axi4_aw_valid = 1'b0; axi4_ar_valid = 1'b0;
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;

      // Simultaneous requests: write wins, then pending read beats a new write.
      track_grants = 1'b1;
      gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
      push_bram(16'h0040, 8'hFF, 64'hA5A5_0000_1111_2222);
      push_bram(16'h0040, 8'h00, 64'd0);
      push_bram(16'h0048, 8'hFF, 64'h5A5A_0000_3333_4444);
      respq.push_back(4'd2); respq.push_back(4'd4);
      push_r(4'd3, 64'hA5A5_0000_1111_2222, 1'b1);
      fork
         begin aw_send(4'd2, 16'h0040, 8'd0, 3'd3, 2'b01); aw_send(4'd4, 16'h0048, 8'd0, 3'd3, 2'b01); end
         ar_send(4'd3, 16'h0040, 8'd0, 3'd3, 2'b01);
         begin w_send(64'hA5A5_0000_1111_2222, 8'hFF, 1'b1); w_send(64'h5A5A_0000_3333_4444, 8'hFF, 1'b1); end
      join
      drain();
      track_grants = 1'b0;
      chk("grants_consumed", 64'(gq.size()), 64'd0);

      // Single-beat write.
      push_bram(16'h0008, 8'hFF, 64'h1122_3344_5566_7788);
      respq.push_back(4'd5);
      fork
         aw_send(4'd5, 16'h0008, 8'd0, 3'd3, 2'b01);
         w_send(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
      join
      drain();

      // Fill 0x10..0x38 with a known pattern.
      for (int i = 0; i < 6; i++) push_bram(16'h0010 + 16'(i * 8), 8'hFF, pat(16'h0010 + 16'(i * 8)));
      respq.push_back(4'd1);
      fork
         aw_send(4'd1, 16'h0010, 8'd5, 3'd3, 2'b01);
         for (int i = 0; i < 6; i++) w_send(pat(16'h0010 + 16'(i * 8)), 8'hFF, i == 5);
      join
      drain();

      // INCR read with backpressure on beat 2.
      for (int i = 0; i < 4; i++) begin
         push_bram(16'h0010 + 16'(i * 8), 8'h00, 64'd0);
         push_r(4'd9, pat(16'h0010 + 16'(i * 8)), i == 3);
      end
      fork
         ar_send(4'd9, 16'h0010, 8'd3, 3'd3, 2'b01);
         begin
            n = 0;
            @(negedge clock);
            while (!(axi4_r_valid && axi4_r_ready) && n < 100) begin @(negedge clock); n++; end
            if (n >= 100) fail_now("r_beat1_wait");
            @(posedge clock); #1;
            axi4_r_ready = 1'b0;
            n = 0;
            @(negedge clock);
            while (!axi4_r_valid && n < 100) begin @(negedge clock); n++; end
            if (n >= 100) fail_now("r_beat2_wait");
            for (int k = 0; k < 5; k++) begin
               chk("hold_r_valid", 64'(axi4_r_valid), 64'd1);
               chk("hold_r_data", axi4_r_data, pat(16'h0018));
               @(negedge clock);
            end
            @(posedge clock); #1;
            axi4_r_ready = 1'b1;
         end
      join
      drain();

      // WRAP read.
      push_bram(16'h0030, 8'h00, 64'd0); push_r(4'hA, pat(16'h0030), 1'b0);
      push_bram(16'h0038, 8'h00, 64'd0); push_r(4'hA, pat(16'h0038), 1'b0);
      push_bram(16'h0020, 8'h00, 64'd0); push_r(4'hA, pat(16'h0020), 1'b0);
      push_bram(16'h0028, 8'h00, 64'd0); push_r(4'hA, pat(16'h0028), 1'b1);
      ar_send(4'hA, 16'h0030, 8'd3, 3'd3, 2'b10);
      drain();

      // Narrow byte write, then read the word back.
      push_bram(16'h0000, 8'h04, 64'h0000_0000_00AA_0000);
      push_bram(16'h0000, 8'h08, 64'h0000_0000_BB00_0000);
      respq.push_back(4'd6);
      fork
         aw_send(4'd6, 16'h0002, 8'd1, 3'd0, 2'b01);
         begin
            w_send(64'h0000_0000_00AA_0000, 8'h04, 1'b0);
            w_send(64'h0000_0000_BB00_0000, 8'h08, 1'b1);
         end
      join
      drain();
      push_bram(16'h0000, 8'h00, 64'd0);
      push_r(4'd6, 64'h0000_0000_BBAA_0000, 1'b1);
      ar_send(4'd6, 16'h0000, 8'd0, 3'd3, 2'b01);
      drain();

      // Asynchronous reset while a read beat is presented.
      axi4_r_ready = 1'b0;
      push_bram(16'h0010, 8'h00, 64'd0);
      ar_send(4'd7, 16'h0010, 8'd0, 3'd3, 2'b01);
      n = 0;
      @(negedge clock);
      while (!axi4_r_valid && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) fail_now("r_valid_before_reset");
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst_r_valid", 64'(axi4_r_valid), 64'd0);
      chk("async_rst_r_data", axi4_r_data, 64'd0);
      chk("async_rst_r_id", 64'(axi4_r_id), 64'd0);
      rq.delete();
      bq.delete();
      @(posedge clock); #1;
      resetn = 1'b1;
      axi4_r_ready = 1'b1;
      push_bram(16'h0018, 8'h00, 64'd0);
      push_r(4'd6, pat(16'h0018), 1'b1);
      ar_send(4'd6, 16'h0018, 8'd0, 3'd3, 2'b01);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
